// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel arbiter in front of the shared SDRAM controller.
// Every requester gets a registered request/acknowledge handshake. Read data
// is latched once per completed read. A channel that holds lock keeps the
// memory for its next request without re-arbitration.
// Optional build macro MEM_ARB_RR_EN: channel 0 keeps absolute priority and
// channels 1..CHANNELS-1 share the memory round-robin. Without the macro,
// arbitration is pure fixed priority (the lowest index wins).
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int CHANNELS = 4,
    parameter int AW       = 25,
    parameter int DW       = 8
) (
    input  logic                   clk_sys,
    input  logic                   nRESET,
    input  logic [CHANNELS-1:0]    req,
    input  logic [CHANNELS-1:0]    we,
    input  logic [CHANNELS-1:0]    lock,
    input  logic [CHANNELS*AW-1:0] addr,
    input  logic [CHANNELS*DW-1:0] din,
    output logic [CHANNELS-1:0]    grant,
    output logic [CHANNELS-1:0]    ack,
    output logic [DW-1:0]          dout,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_din,
    output logic                   mem_we,
    output logic                   mem_rd,
    output logic                   mem_req,
    input  logic                   mem_ready,
    input  logic [DW-1:0]          mem_dout
);

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_owner;
    logic          r_lock_vld;
    logic [IW-1:0] r_lock_own;
`ifdef MEM_ARB_RR_EN
    logic [IW-1:0] r_rr_ptr;
    logic [IW:0]   w_rr_idx;
`endif

    logic          w_win_vld;
    logic [IW-1:0] w_win;
    logic [AW-1:0] w_addr [CHANNELS];
    logic [DW-1:0] w_din  [CHANNELS];

    // Unpack the flattened per-channel address and data buses.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign w_addr[gi] = addr[gi*AW +: AW];
        assign w_din[gi]  = din[gi*DW +: DW];
    end

    // Winner selection: a live lock wins outright, otherwise priority applies.
    always_comb begin
        w_win_vld = 1'b0;
        w_win     = '0;
`ifdef MEM_ARB_RR_EN
        w_rr_idx  = '0;
`endif
        if (r_lock_vld && req[r_lock_own]) begin
            w_win_vld = 1'b1;
            w_win     = r_lock_own;
        end
`ifdef MEM_ARB_RR_EN
        else if (req[0]) begin
            w_win_vld = 1'b1;
            w_win     = '0;
        end else begin
            // Walk channels 1..CHANNELS-1 starting at the rotation pointer.
            for (int j = 0; j < CHANNELS-1; j++) begin
                w_rr_idx = {1'b0, r_rr_ptr} + (IW+1)'(j);
                if (w_rr_idx > (IW+1)'(CHANNELS-1))
                    w_rr_idx = w_rr_idx - (IW+1)'(CHANNELS-1);
                if (!w_win_vld && req[w_rr_idx[IW-1:0]]) begin
                    w_win_vld = 1'b1;
                    w_win     = w_rr_idx[IW-1:0];
                end
            end
        end
`else
        else begin
            // Scan downward so the lowest requesting index is the last written.
            for (int c = CHANNELS-1; c >= 0; c--) begin
                if (req[c]) begin
                    w_win_vld = 1'b1;
                    w_win     = IW'(c);
                end
            end
        end
`endif
    end

    // Arbitration FSM. All handshake and memory outputs are registered here.
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_lock_vld <= 1'b0;
            r_lock_own <= '0;
`ifdef MEM_ARB_RR_EN
            r_rr_ptr   <= IW'(1);
`endif
            grant      <= '0;
            ack        <= '0;
            dout       <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_req    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ack <= '0;
                    // The lock lapses as soon as its owner stops requesting.
                    if (r_lock_vld && !req[r_lock_own])
                        r_lock_vld <= 1'b0;
                    if (w_win_vld) begin
                        r_owner  <= w_win;
                        grant    <= CHANNELS'(1) << w_win;
                        mem_addr <= w_addr[w_win];
                        mem_din  <= w_din[w_win];
                        mem_we   <= we[w_win];
                        mem_rd   <= ~we[w_win];
                        mem_req  <= 1'b1;
                        r_state  <= S_WAIT;
`ifdef MEM_ARB_RR_EN
                        if (w_win != '0)
                            r_rr_ptr <= (w_win == IW'(CHANNELS-1)) ? IW'(1) : w_win + IW'(1);
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        if (mem_rd)
                            dout <= mem_dout;
                        mem_req <= 1'b0;
                        ack     <= CHANNELS'(1) << r_owner;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // The owner's request is ignored here; only its lock is sampled.
                    ack        <= '0;
                    grant      <= '0;
                    mem_we     <= 1'b0;
                    mem_rd     <= 1'b0;
                    r_lock_vld <= lock[r_owner];
                    r_lock_own <= r_owner;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
